seq_tx: RTL and testbench

Serial sequence transmitter, the generating end of the single-bit sequence-detection link. It accepts a parallel word over a valid/ready handshake and shifts it out MSB-first on one serial line. Each frame is preceded by the sync preamble 1-1-0-1, which a downstream sequence detector uses to flag frame starts. It sits between a parallel producer and the serial channel feeding the detector.

---
 rtl/seq_pkg.sv | 17 +
 rtl/seq_tx_if.sv | 22 ++
 rtl/seq_piso.sv | 23 ++
 rtl/seq_tx.sv | 120 ++++++++++++
 tb/tb_seq_tx.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence link (transmitter and detector side).
package seq_pkg;

  typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} state_t;

  localparam logic [3:0] PREAMBLE = 4'b1101;
  localparam int         PRE_LEN  = 4;

  // Bit counter width: enough to hold the longest phase length minus one.
  function automatic int cnt_width(input int data_w, input int gap_len);
    int m;
    m = (data_w > gap_len) ? data_w : gap_len;
    if (m < PRE_LEN) m = PRE_LEN;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/seq_tx_if.sv
// Producer-side handshake plus serial line outputs of seq_tx.
interface seq_tx_if #(parameter int DATA_W = 8);

  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic              bit_out;
  logic              bit_valid;
  logic              busy;
  logic              frame_done;

  modport master (
    output data_in, data_valid,
    input  data_ready, bit_out, bit_valid, busy, frame_done
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, bit_out, bit_valid, busy, frame_done
  );

endinterface

// File: rtl/seq_piso.sv
// Parallel-load, MSB-first shift register; load has priority over shift.
module seq_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     sreg <= '0;
    else if (load)  sreg <= din;
    else if (shift) sreg <= sreg << 1;
  end

  assign sout = sreg[WIDTH-1];

endmodule

// File: rtl/seq_tx.sv
// Serial sequence transmitter: 1101 preamble (when PREAMBLE_EN is defined) then
// DATA_W payload bits MSB-first, then GAP idle-low cycles.
//
// state | meaning
// IDLE  | waiting for a word, data_ready high, line low
// PRE   | emitting the preamble bits
// DATA  | emitting payload bits MSB-first
// GAP   | line low for GAP cycles before returning to IDLE
module seq_tx #(
  parameter int DATA_W = 8,
  parameter int GAP    = 1
) (
  input  logic     clock,
  input  logic     reset,
  seq_tx_if.slave  bus
);
  import seq_pkg::*;

  localparam int CNT_W = cnt_width(DATA_W, GAP);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               bit_q;
  logic               valid_q;
  logic               done_q;
  logic               sout;
  logic               load;
  logic               shift;
  logic [DATA_W-1:0]  load_val;

  assign load = (state == IDLE) && bus.data_valid;

`ifdef PREAMBLE_EN
  assign load_val = bus.data_in;
  assign shift    = ((state == PRE) && (cnt == '0)) || ((state == DATA) && (cnt != '0));
`else
  // The first payload bit leaves straight from data_in on the accept edge.
  assign load_val = bus.data_in << 1;
  assign shift    = (state == DATA) && (cnt != '0);
`endif

  seq_piso #(.WIDTH(DATA_W)) u_piso (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .din   (load_val),
    .sout  (sout)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          bit_q   <= 1'b0;
          valid_q <= 1'b0;
          if (bus.data_valid) begin
            valid_q <= 1'b1;
`ifdef PREAMBLE_EN
            state   <= PRE;
            cnt     <= CNT_W'(PRE_LEN - 1);
            bit_q   <= PREAMBLE[PRE_LEN-1];
`else
            state   <= DATA;
            cnt     <= CNT_W'(DATA_W - 1);
            bit_q   <= bus.data_in[DATA_W-1];
            done_q  <= (DATA_W == 1);
`endif
          end
        end
        PRE: begin
          if (cnt != '0) begin
            cnt   <= cnt - 1'b1;
            bit_q <= PREAMBLE[cnt[1:0] - 2'd1];
          end else begin
            state  <= DATA;
            cnt    <= CNT_W'(DATA_W - 1);
            bit_q  <= sout;
            done_q <= (DATA_W == 1);
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt    <= cnt - 1'b1;
            bit_q  <= sout;
            done_q <= (cnt == CNT_W'(1));
          end else begin
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            if (GAP > 0) begin
              state <= seq_pkg::GAP;
              cnt   <= CNT_W'(GAP - 1);
            end else begin
              state <= IDLE;
            end
          end
        end
        seq_pkg::GAP: begin
          if (cnt != '0) cnt   <= cnt - 1'b1;
          else           state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_ready = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.bit_out    = bit_q;
  assign bus.bit_valid  = valid_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_seq_tx.sv
// Scoreboard bench for seq_tx: two instances (DATA_W=8/GAP=1 and DATA_W=4/GAP=0).
module tb_seq_tx;

  localparam int WA = 8;
  localparam int GA = 1;
  localparam int WB = 4;
  localparam int GB = 0;
`ifdef PREAMBLE_EN
  localparam int PRE = 4;
`else
  localparam int PRE = 0;
`endif

  typedef struct {
    logic b;
    logic fd;
    int   cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  seq_tx_if #(.DATA_W(WA)) ia ();
  seq_tx_if #(.DATA_W(WB)) ib ();

  seq_tx #(.DATA_W(WA), .GAP(GA)) u_a (.clock(clock), .reset(reset), .bus(ia));
  seq_tx #(.DATA_W(WB), .GAP(GB)) u_b (.clock(clock), .reset(reset), .bus(ib));

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  bit   sel = 1'b0;
  int   acc_lo = 1 << 30;
  int   acc_hi = -1;
  int   last_acc = 0;
  logic [3:0] pre_bits = 4'b1101;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t (cycle %0d): got %0h expected %0h", tag, $time, cyc, got, exp);
    end
  endtask

  always @(negedge clock) begin
    logic o_bit, o_bv, o_fd, o_busy, o_rdy, e_busy;
    exp_t e;
    if (mon_en) begin
      o_bit  = sel ? ib.bit_out    : ia.bit_out;
      o_bv   = sel ? ib.bit_valid  : ia.bit_valid;
      o_fd   = sel ? ib.frame_done : ia.frame_done;
      o_busy = sel ? ib.busy       : ia.busy;
      o_rdy  = sel ? ib.data_ready : ia.data_ready;
      e_busy = (cyc >= acc_lo) && (cyc <= acc_hi);
      check("busy", o_busy, e_busy);
      check("data_ready", o_rdy, !e_busy);
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        check("bit_valid", o_bv, 1'b1);
        check("bit_out", o_bit, e.b);
        check("frame_done", o_fd, e.fd);
      end else begin
        check("idle_bit_valid", o_bv, 1'b0);
        check("idle_bit_out", o_bit, 1'b0);
        check("idle_frame_done", o_fd, 1'b0);
      end
    end
  end

  task automatic send(input logic [31:0] w, input bit hold);
    int n, wd, gp, e0;
    exp_t e;
    wd = sel ? WB : WA;
    gp = sel ? GB : GA;
    @(negedge clock);
    if (sel) begin ib.data_in = w[WB-1:0]; ib.data_valid = 1'b1; end
    else     begin ia.data_in = w[WA-1:0]; ia.data_valid = 1'b1; end
    n = 0;
    while (!(sel ? ib.data_ready : ia.data_ready) && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("accept_wait", (n < 100), 1'b1);
    e0 = cyc + 1;
    for (int i = 0; i < PRE; i++) begin
      e.b = pre_bits[3-i]; e.fd = 1'b0; e.cyc = e0 + i;
      sb.push_back(e);
    end
    for (int j = 0; j < wd; j++) begin
      e.b = w[wd-1-j]; e.fd = (j == wd - 1); e.cyc = e0 + PRE + j;
      sb.push_back(e);
    end
    acc_lo   = e0;
    acc_hi   = e0 + PRE + wd + gp - 1;
    last_acc = e0;
    @(posedge clock);
    #1;
    if (!hold) begin
      ia.data_valid = 1'b0;
      ib.data_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    check("drain", sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [4:0] got;
    got = sel ? {ib.bit_out, ib.bit_valid, ib.frame_done, ib.busy, ib.data_ready}
              : {ia.bit_out, ia.bit_valid, ia.frame_done, ia.busy, ia.data_ready};
    check(tag, got, 5'b00001);
  endtask

  initial begin
    int a1;
    ia.data_in = '0; ia.data_valid = 1'b0;
    ib.data_in = '0; ib.data_valid = 1'b0;

    repeat (2) @(negedge clock);
    sel = 1'b0; check_reset_outputs("reset_a");
    sel = 1'b1; check_reset_outputs("reset_b");
    sel = 1'b0;
    reset = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(negedge clock);

    send(32'hA5, 1'b0);
    drain();

    send(32'hFF, 1'b1);
    a1 = last_acc;
    send(32'h00, 1'b0);
    check("accept_spacing", last_acc - a1, PRE + WA + GA + 1);
    drain();

    for (int k = 0; k < 4; k++) send($urandom_range(0, 255), 1'b0);
    drain();

    // Abort a frame during its third payload bit.
    send(32'hA5, 1'b0);
    begin
      int n;
      n = 0;
      while (cyc != last_acc + PRE + 2 && n < 50) begin
        @(negedge clock);
        n++;
      end
      check("reset_reach", cyc, last_acc + PRE + 2);
    end
    #2;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    check_reset_outputs("reset_midframe");
    sb.delete();
    acc_lo = 1 << 30;
    acc_hi = -1;
    repeat (2) @(negedge clock);
    check_reset_outputs("reset_held");
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clock);
    send(32'hA5, 1'b0);
    drain();

    sel = 1'b1;
    repeat (2) @(negedge clock);
    send(32'h1, 1'b0);
    drain();
    send(32'hC, 1'b1);
    a1 = last_acc;
    send(32'h9, 1'b0);
    check("accept_spacing_b", last_acc - a1, PRE + WB + GB + 1);
    drain();

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
